// File: rtl/keystream_xor_cipher.sv
// Keystream XOR cipher: packs random key words into a bit reservoir and XORs
// 8-bit slices of it (LSB-first) with the byte stream; encryption and decryption are identical.
module keystream_xor_cipher #(
    parameter int KEY_W  = 11,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic              sync_clr,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [CNT_W-1:0]  byte_cnt
);

    localparam int RES_W  = KEY_W + DATA_W - 1;
    localparam int FILL_W = $clog2(RES_W + 1);
    localparam logic [FILL_W-1:0] KEY_BITS  = FILL_W'(KEY_W);
    localparam logic [FILL_W-1:0] BYTE_BITS = FILL_W'(DATA_W);

    logic [RES_W-1:0]  reservoir_q, reservoir_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic              key_fire, byte_fire;

    // A key word is only taken when it is guaranteed to fit above the current fill,
    // and a byte only when 8 bits are present, so the two handshakes never coincide.
    always_comb begin
        key_ready    = rst_n && !sync_clr && (fill_q < BYTE_BITS);
        din_ready    = rst_n && !sync_clr && (fill_q >= BYTE_BITS) &&
                       (!dout_valid_q || dout_ready);
        key_fire     = key_valid && key_ready;
        byte_fire    = din_valid && din_ready;

        reservoir_d  = reservoir_q;
        fill_d       = fill_q;
        dout_d       = dout_q;
        byte_cnt_d   = byte_cnt_q;
        dout_valid_d = byte_fire || (dout_valid_q && !dout_ready);

        if (sync_clr) begin
            reservoir_d = '0;
            fill_d      = '0;
            byte_cnt_d  = '0;
        end else if (key_fire) begin
            reservoir_d = reservoir_q | (RES_W'(key_in) << fill_q);
            fill_d      = fill_q + KEY_BITS;
        end else if (byte_fire) begin
            dout_d      = din ^ reservoir_q[DATA_W-1:0];
            reservoir_d = reservoir_q >> DATA_W;
            fill_d      = fill_q - BYTE_BITS;
            byte_cnt_d  = byte_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reservoir_q  <= '0;
            fill_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            reservoir_q  <= reservoir_d;
            fill_q       <= fill_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            byte_cnt_q   <= byte_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign byte_cnt   = byte_cnt_q;

endmodule
